coderom_busctl: RTL and testbench

CODEROM_BUSCTL -- requirements
Module: coderom_busctl

---
 rtl/coderom_busctl.sv | 116 +++++++++++
 tb/tb_coderom_busctl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coderom_busctl.sv
// coderom_busctl: 68000 bus controller for a 4 x 8K-word code ROM bank in the bottom 64 KB.
// Defining CODEROM_HITCACHE_EN adds a one-entry read cache that acknowledges repeat reads early.
module coderom_busctl (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:1] cpu_a,
   input  logic        cpu_as_n,
   input  logic        cpu_rw,
   output logic        cpu_dtack_n,
   output logic [15:0] cpu_din,
   output logic [12:0] rom_a,
   output logic [3:0]  rom_ce_n,
   input  logic [15:0] rom_d,
   output logic        rom_sel,
   output logic        wr_err
);

   typedef enum logic [1:0] {IDLE, SETUP, CAPTURE, ACK} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [12:0] r_rom_a;
   logic [3:0]  r_ce_n;
   logic [15:0] r_din;
   logic        r_dtack_n;
   logic        r_sel;
   logic        r_wr_err;

   logic        w_hit;
   logic        w_start;
   logic        w_capture;
   logic        w_enter_setup;
   logic        w_cache_hit;
   logic [15:0] w_cache_data;

   assign w_hit         = (cpu_a[23:16] == 8'h00);
   assign w_start       = (r_state == IDLE) && !cpu_as_n && w_hit;
   assign w_capture     = (r_state == CAPTURE) && !cpu_as_n;
   assign w_enter_setup = (w_state_next == SETUP);

`ifdef CODEROM_HITCACHE_EN
   logic        r_cache_valid;
   logic [14:0] r_cache_tag;
   logic [15:0] r_cache_data;
   logic [14:0] r_fill_tag;

   assign w_cache_hit  = r_cache_valid && (r_cache_tag == cpu_a[15:1]);
   assign w_cache_data = r_cache_data;

   // Entry is refilled only when a ROM fetch completes; aborted fetches leave it untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cache_valid <= 1'b0;
         r_cache_tag   <= '0;
         r_cache_data  <= '0;
         r_fill_tag    <= '0;
      end else begin
         if (w_enter_setup)
            r_fill_tag <= cpu_a[15:1];
         if (w_capture) begin
            r_cache_valid <= 1'b1;
            r_cache_tag   <= r_fill_tag;
            r_cache_data  <= rom_d;
         end
      end
   end
`else
   assign w_cache_hit  = 1'b0;
   assign w_cache_data = 16'h0000;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_next = (!cpu_rw || w_cache_hit) ? ACK : SETUP;
         SETUP:   w_state_next = cpu_as_n ? IDLE : CAPTURE;
         CAPTURE: w_state_next = cpu_as_n ? IDLE : ACK;
         ACK:     if (cpu_as_n) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to;
   // dtack is registered from the current state, giving one extra cycle after ACK is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_rom_a   <= '0;
         r_ce_n    <= 4'b1111;
         r_din     <= '0;
         r_dtack_n <= 1'b1;
         r_sel     <= 1'b0;
         r_wr_err  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_sel     <= (w_state_next != IDLE);
         r_wr_err  <= w_start && !cpu_rw;
         r_dtack_n <= !((r_state == ACK) && !cpu_as_n);
         r_ce_n    <= w_enter_setup ? ~(4'b0001 << cpu_a[15:14]) : 4'b1111;
         if (w_enter_setup)
            r_rom_a <= cpu_a[13:1];
         if (w_capture)
            r_din <= rom_d;
         else if (w_start && cpu_rw && w_cache_hit)
            r_din <= w_cache_data;
      end
   end

   assign cpu_dtack_n = r_dtack_n;
   assign cpu_din     = r_din;
   assign rom_a       = r_rom_a;
   assign rom_ce_n    = r_ce_n;
   assign rom_sel     = r_sel;
   assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_coderom_busctl.sv
// Scoreboard bench for coderom_busctl: driver queues expected responses, monitor checks on dtack.
// Honours CODEROM_HITCACHE_EN so the reference model matches the build being simulated.
module tb_coderom_busctl;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:1] cpu_a;
   logic        cpu_as_n;
   logic        cpu_rw;
   logic        cpu_dtack_n;
   logic [15:0] cpu_din;
   logic [12:0] rom_a;
   logic [3:0]  rom_ce_n;
   logic [15:0] rom_d;
   logic        rom_sel;
   logic        wr_err;

   always #5 clk = ~clk;

   coderom_busctl dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_a       (cpu_a),
      .cpu_as_n    (cpu_as_n),
      .cpu_rw      (cpu_rw),
      .cpu_dtack_n (cpu_dtack_n),
      .cpu_din     (cpu_din),
      .rom_a       (rom_a),
      .rom_ce_n    (rom_ce_n),
      .rom_d       (rom_d),
      .rom_sel     (rom_sel),
      .wr_err      (wr_err)
   );

   typedef struct {
      int          start;
      int          lat;
      bit          rd;
      logic [15:0] data;
      int          ce_cycles;
      logic [3:0]  ce;
      logic [12:0] rom_a;
      int          wr;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] rom_mem [0:32767];
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   bit          quiet_chk = 1'b0;
   bit          rst_chk = 1'b0;
   bit          done = 1'b0;
`ifdef CODEROM_HITCACHE_EN
   bit          mdl_cache_valid = 1'b0;
   logic [14:0] mdl_cache_tag = '0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] ce_chip(input logic [3:0] ce_n);
      case (ce_n)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // ROM bank: data appears one clock after an enabled address is sampled.
   always @(posedge clk) begin
      if (rom_ce_n != 4'hF)
         rom_d <= rom_mem[{ce_chip(rom_ce_n), rom_a}];
      else
         rom_d <= 16'hDEAD;
   end

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: owns all comparisons.
   exp_t       mon_e;
   int         ce_cycles = 0;
   int         wr_cnt = 0;
   logic [3:0] last_ce = 4'hF;
   logic [12:0] last_rom_a = '0;
   logic       prev_dtack = 1'b1;
   logic       prev_wr = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_chk) begin
            chk("reset_ctl", 32'({cpu_dtack_n, rom_sel, wr_err, rom_ce_n}), 32'({1'b1, 1'b0, 1'b0, 4'hF}));
            chk("reset_data", 32'({rom_a, cpu_din}), 0);
         end else if (reset) begin
            // nothing observable expected while reset is being held
         end else if (quiet_chk) begin
            chk("idle_outputs", 32'({cpu_dtack_n, rom_sel, rom_ce_n}), 32'({1'b1, 1'b0, 4'hF}));
         end else begin
            if (rom_ce_n != 4'hF) begin
               ce_cycles++;
               last_ce    = rom_ce_n;
               last_rom_a = rom_a;
               chk("ce_onehot", $countones(~rom_ce_n), 1);
            end
            if (wr_err) begin
               wr_cnt++;
               chk("wr_err_width", 32'(prev_wr), 0);
            end
            if (prev_dtack && !cpu_dtack_n) begin
               if (sb.size() == 0) begin
                  chk("unexpected_ack", 1, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("latency", cyc - mon_e.start, mon_e.lat);
                  if (mon_e.rd) chk("read_data", 32'(cpu_din), 32'(mon_e.data));
                  chk("rom_sel_in_ack", 32'(rom_sel), 1);
                  chk("ce_cycles", ce_cycles, mon_e.ce_cycles);
                  if (mon_e.ce_cycles != 0) begin
                     chk("ce_pattern", 32'(last_ce), 32'(mon_e.ce));
                     chk("rom_addr", 32'(last_rom_a), 32'(mon_e.rom_a));
                  end
                  chk("wr_err_count", wr_cnt, mon_e.wr);
               end
            end else if (sb.size() > 0 && (cyc - sb[0].start) > 10) begin
               chk("ack_timeout", 1, 0);
               void'(sb.pop_front());
            end
         end
         if (cpu_as_n || reset) begin
            ce_cycles = 0;
            wr_cnt    = 0;
         end
         prev_dtack = cpu_dtack_n;
         prev_wr    = wr_err;
         if (done) begin
            chk("scoreboard_drained", sb.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
         end
      end
   end

   // One bus cycle. abort_ph: 1 = drop strobe in SETUP, 2 = in CAPTURE. rst_ack: reset while acknowledged.
   task automatic run_txn(input logic [23:0] ba, input bit rd, input int abort_ph, input bit rst_ack);
      exp_t e;
      bit   hit;
      bit   chit;
      hit  = (ba[23:16] == 8'h00);
      chit = 1'b0;
`ifdef CODEROM_HITCACHE_EN
      chit = rd && mdl_cache_valid && (mdl_cache_tag == ba[15:1]);
`endif
      @(negedge clk);
      cpu_a    = ba[23:1];
      cpu_rw   = rd;
      cpu_as_n = 1'b0;
      if (!hit) begin
         @(posedge clk); #1 quiet_chk = 1'b1;
         repeat (3) @(negedge clk);
         cpu_as_n = 1'b1;
         @(posedge clk); #1 quiet_chk = 1'b0;
         return;
      end
      if (abort_ph != 0 && rd && !chit) begin
         repeat (abort_ph) @(negedge clk);
         cpu_as_n = 1'b1;
         @(posedge clk); #1 quiet_chk = 1'b1;
         repeat (2) @(negedge clk);
         @(posedge clk); #1 quiet_chk = 1'b0;
         return;
      end
      e.start     = cyc + 1;
      e.rd        = rd;
      e.lat       = (rd && !chit) ? 3 : 1;
      e.data      = rd ? rom_mem[ba[15:1]] : 16'h0000;
      e.ce_cycles = (rd && !chit) ? 1 : 0;
      e.ce        = ~(4'b0001 << ba[15:14]);
      e.rom_a     = ba[13:1];
      e.wr        = rd ? 0 : 1;
      sb.push_back(e);
`ifdef CODEROM_HITCACHE_EN
      if (rd && !chit) begin
         mdl_cache_valid = 1'b1;
         mdl_cache_tag   = ba[15:1];
      end
`endif
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!cpu_dtack_n) break;
      end
      if (rst_ack) begin
         reset = 1'b1;
         @(posedge clk); #1 rst_chk = 1'b1;
         @(negedge clk); #1 rst_chk = 1'b0;
         reset    = 1'b0;
         cpu_as_n = 1'b1;
`ifdef CODEROM_HITCACHE_EN
         mdl_cache_valid = 1'b0;
`endif
         @(negedge clk);
         return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cpu_as_n = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [23:0] last_rd;
   logic [23:0] ba;
   int          r;

   initial begin
      reset    = 1'b1;
      cpu_as_n = 1'b1;
      cpu_rw   = 1'b1;
      cpu_a    = '0;
      for (int i = 0; i < 32768; i++) rom_mem[i] = 16'($urandom);
      rom_mem[1] = 16'h7578;
      repeat (2) @(posedge clk);
      #1 rst_chk = 1'b1;
      @(negedge clk); #1 rst_chk = 1'b0;
      reset = 1'b0;

      run_txn(24'h000002, 1'b1, 0, 1'b0);
      run_txn(24'h00C000, 1'b1, 0, 1'b0);
      run_txn(24'h010000, 1'b1, 0, 1'b0);
      run_txn(24'h000100, 1'b0, 0, 1'b0);
      run_txn(24'h000006, 1'b1, 0, 1'b0);
      run_txn(24'h000006, 1'b1, 0, 1'b0);
      run_txn(24'h004010, 1'b1, 2, 1'b0);
      run_txn(24'h008020, 1'b1, 1, 1'b0);
      run_txn(24'h00A000, 1'b1, 0, 1'b1);
      run_txn(24'h00A000, 1'b1, 0, 1'b0);

      last_rd = 24'h00A000;
      for (int t = 0; t < 80; t++) begin
         r  = int'($urandom_range(0, 99));
         ba = {8'h00, 15'($urandom), 1'b0};
         if (r < 10) begin
            ba = {8'($urandom_range(1, 255)), 15'($urandom), 1'b0};
            run_txn(ba, 1'b1, 0, 1'b0);
         end else if (r < 25) begin
            run_txn(ba, 1'b0, 0, 1'b0);
         end else if (r < 40) begin
            run_txn(last_rd, 1'b1, 0, 1'b0);
         end else if (r < 50) begin
            run_txn(ba, 1'b1, int'($urandom_range(1, 2)), 1'b0);
         end else begin
            run_txn(ba, 1'b1, 0, 1'b0);
            last_rd = ba;
         end
      end

      repeat (5) @(negedge clk);
      #1 done = 1'b1;
   end

endmodule
